fsm_behave: RTL and testbench



---
 rtl/fsm_behave_pkg.sv | 38 +++
 rtl/fsm_behave_decode.sv | 23 ++
 rtl/fsm_behave.sv | 64 ++++++
 tb/tb_fsm_behave.sv | 121 ++++++++++++
 4 files changed

// File: rtl/fsm_behave_pkg.sv
// Shared types and constants for the fsm_behave instruction sequencer.
// The 24 sequencer states, the instruction class lengths and the decision points.
package fsm_behave_pkg;

  localparam int NUM_STATES = 24;
  localparam int STATE_W    = 5;

  typedef enum logic [STATE_W-1:0] {
    S1  = 5'd0,  S2  = 5'd1,  S3  = 5'd2,  S4  = 5'd3,
    S5  = 5'd4,  S6  = 5'd5,  S7  = 5'd6,  S8  = 5'd7,
    S9  = 5'd8,  S10 = 5'd9,  S11 = 5'd10, S12 = 5'd11,
    S13 = 5'd12, S14 = 5'd13, S15 = 5'd14, S16 = 5'd15,
    S17 = 5'd16, S18 = 5'd17, S19 = 5'd18, S20 = 5'd19,
    S21 = 5'd20, S22 = 5'd21, S23 = 5'd22, S24 = 5'd23
  } state_t;

  typedef enum logic [1:0] {
    CLS_8  = 2'd0,
    CLS_12 = 2'd1,
    CLS_14 = 2'd2,
    CLS_24 = 2'd3
  } cls_t;

  // States where the instruction class is sampled, plus the final state.
  localparam state_t DEC_S8  = S8;
  localparam state_t DEC_S12 = S12;
  localparam state_t DEC_S14 = S14;
  localparam state_t LAST_S  = S24;

  // One-hot decode: bit n-1 set in state Sn; unused codes decode to zero.
  function automatic logic [NUM_STATES-1:0] state_onehot(input state_t s);
    logic [NUM_STATES-1:0] vec;
    vec = '0;
    if (s <= LAST_S) vec[s] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/fsm_behave_decode.sv
// Combinational decode of the four instruction MSBs into a class length.
module fsm_behave_decode
  import fsm_behave_pkg::*;
(
  input  logic [3:0] instruction_bits,
  output cls_t       cls
);

  always_comb begin
    cls = CLS_8;
    casez (instruction_bits)
      4'b00??: cls = CLS_8;   // MOV-8
      4'b01??: cls = CLS_8;   // SETAB / load immediate
      4'b1000: cls = CLS_8;   // ALU
      4'b1001: cls = CLS_12;  // LOAD/STORE
      4'b1010: cls = CLS_12;  // MOV-16 / HALT / RETURN / BRANCH
      4'b1011: cls = CLS_14;  // INC
      4'b11??: cls = CLS_24;  // GOTO class
      default: cls = CLS_8;
    endcase
  end

endmodule

// File: rtl/fsm_behave.sv
// Moore instruction sequencer S1..S24 with a one-hot state output.
// Optional simulation checks are enabled with the macro FSM_BEHAVE_ASSERT_EN.
module fsm_behave
  import fsm_behave_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            instruction_bits,
  output logic [NUM_STATES-1:0] outputState
);

  state_t state;
  state_t next_state;
  cls_t   cls;

  fsm_behave_decode u_decode (
    .instruction_bits (instruction_bits),
    .cls              (cls)
  );

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values; blocking here would create ordering races.
  always_ff @(posedge clock) begin
    if (reset) state <= S1;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = S1;
    case (state)
      DEC_S8:  next_state = (cls == CLS_8)  ? S1 : S9;
      DEC_S12: next_state = (cls == CLS_12) ? S1 : S13;
      DEC_S14: next_state = (cls == CLS_14) ? S1 : S15;
      LAST_S:  next_state = S1;
      // Unused codes 24..31 fall through to S1.
      default: next_state = (state < LAST_S) ? state_t'(state + 5'd1) : S1;
    endcase
  end

  assign outputState = state_onehot(state);

`ifdef FSM_BEHAVE_ASSERT_EN
  always @(posedge clock) begin
    if (!reset) begin
      assert ($onehot(outputState))
        else $error("outputState not one-hot: %h", outputState);
      case (state)
        DEC_S8:  assert (next_state == S1 || next_state == S9)
                   else $error("illegal successor of S8");
        DEC_S12: assert (next_state == S1 || next_state == S13)
                   else $error("illegal successor of S12");
        DEC_S14: assert (next_state == S1 || next_state == S15)
                   else $error("illegal successor of S14");
        LAST_S:  assert (next_state == S1)
                   else $error("illegal successor of S24");
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_fsm_behave.sv
// Directed bench for fsm_behave: class lengths, decision sampling and reset.
module tb_fsm_behave;

  logic        clock;
  logic        reset;
  logic [3:0]  instruction_bits;
  logic [23:0] outputState;

  int passed = 0;
  int total  = 0;

  fsm_behave dut (
    .clock            (clock),
    .reset            (reset),
    .instruction_bits (instruction_bits),
    .outputState      (outputState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected one-hot code for state Sn.
  function automatic logic [23:0] sn(input int n);
    logic [23:0] v;
    v = 24'h000001;
    return v << (n - 1);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] observed,
                       input logic [23:0] expected);
    total++;
    assert (observed === expected) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  // From S1, hold bits and expect S2..S<len> then S1.
  task automatic run_instr(input string tag, input logic [3:0] bits, input int len);
    instruction_bits = bits;
    for (int n = 2; n <= len; n++) begin
      step();
      check($sformatf("%s_S%0d", tag, n), outputState, sn(n));
    end
    step();
    check($sformatf("%s_wrap", tag), outputState, 24'h000001);
  endtask

  initial begin
    reset = 1'b1;
    instruction_bits = 4'b0000;
    step();
    check("reset_s1", outputState, 24'h000001);
    step();
    check("reset_hold", outputState, 24'h000001);
    reset = 1'b0;

    run_instr("mov8",   4'b0000, 8);
    run_instr("ldst",   4'b1001, 12);
    run_instr("mov16",  4'b1010, 12);
    run_instr("inc",    4'b1011, 14);
    run_instr("goto",   4'b1100, 24);
    run_instr("setab",  4'b0110, 8);
    run_instr("alu",    4'b1000, 8);

    // ALU during S1..S7, GOTO presented at S8: long path taken.
    instruction_bits = 4'b1000;
    for (int n = 2; n <= 8; n++) step();
    check("chg_at_s8", outputState, sn(8));
    instruction_bits = 4'b1100;
    step();
    check("chg_s9", outputState, sn(9));
    // Bits flip between decisions; only the values at S12/S14 matter.
    instruction_bits = 4'b1001;
    step();
    check("chg_s10", outputState, sn(10));
    instruction_bits = 4'b1100;
    step();
    step();
    check("chg_s12", outputState, sn(12));
    step();
    check("chg_s13", outputState, sn(13));
    step();
    check("chg_s14", outputState, sn(14));
    step();
    check("chg_s15", outputState, sn(15));
    instruction_bits = 4'b0000;
    for (int n = 16; n <= 24; n++) step();
    check("chg_s24", outputState, sn(24));
    step();
    check("chg_wrap", outputState, 24'h000001);

    // GOTO during S1..S7, SETAB presented at S8: short path taken.
    instruction_bits = 4'b1100;
    for (int n = 2; n <= 8; n++) step();
    check("short_s8", outputState, sn(8));
    instruction_bits = 4'b0100;
    step();
    check("short_wrap", outputState, 24'h000001);

    // Reset mid-instruction at S17.
    instruction_bits = 4'b1100;
    for (int n = 2; n <= 17; n++) step();
    check("pre_reset_s17", outputState, sn(17));
    reset = 1'b1;
    step();
    check("mid_reset_s1", outputState, 24'h000001);
    reset = 1'b0;
    step();
    check("post_reset_s2", outputState, sn(2));
    step();
    check("post_reset_s3", outputState, sn(3));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
